hdmi_video_timing: RTL
======================

Name: hdmi_video_timing

Overview:
- Video timing controller and scheduler for the three HDMI TMDS encoder lanes.
- Generates horizontal and vertical counters, and requests pixels from the frame renderer.
- Drives the encoders' blank input, and the control bits {vsync,hsync} on lane 0 (zero on lanes 1 and 2).
- Sync and blank outputs are delayed by a fixed latency so they line up with the renderer's pixel pipeline. Runs on the pixel clock.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch, in clocks
H_SYNC, 96, hsync pulse width, in clocks
H_BP, 48, horizontal back porch, in clocks
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch, in lines
V_SYNC, 2, vsync pulse width, in lines
V_BP, 33, vertical back porch, in lines
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
PIX_LAT, 2, renderer latency in clocks from pix_req to pixel valid (range 0..7)

Ports:
clk  in  1  pixel clock
arst_n  in  1  asynchronous active-low reset
en  in  1  run request; sampled as described in Behaviour
pix_req  out  1  renderer must present the pixel at (x,y) PIX_LAT clocks later
x  out  12  current horizontal position (counter domain, undelayed)
y  out  12  current vertical position (counter domain, undelayed)
frame_start  out  1  one-clock pulse at h=0, v=0 (undelayed)
line_start  out  1  one-clock pulse at h=0 of every line (undelayed)
blank  out  1  to all encoder blank inputs; delayed by PIX_LAT
ctrl0  out  2  {vsync,hsync} to lane-0 raw.c; delayed by PIX_LAT
hsync  out  1  delayed hsync, at HS_POL level when active
vsync  out  1  delayed vsync, at VS_POL level when active
running  out  1  high while in state RUN

Behaviour:
- Derived totals: H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOT likewise. Both must be ≤4096. Counters are 12-bit unsigned.
- FSM has two states, IDLE and RUN. Reset state is IDLE.
- IDLE → RUN: when en=1 is sampled. The next clock has h=0, v=0, frame_start=1, line_start=1.
- RUN → IDLE: only at the frame's final clock (h=H_TOT-1, v=V_TOT-1), and only if en=0 at that clock.
  - Otherwise h and v wrap to 0 and the next frame begins.
  - en may toggle freely mid-frame without effect; frames are never truncated.
- Counters in RUN:
  - h increments every clock and wraps H_TOT-1 → 0.
  - v increments when h wraps, and wraps V_TOT-1 → 0.
- Counters in IDLE: h and v hold at 0.
- Undelayed signals, combinational from registered counters and state:
  - active = RUN && h<H_ACTIVE && v<V_ACTIVE
  - hs_raw = RUN && H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC
  - vs_raw = RUN && V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC (changes on h=0 boundaries only)
  - pix_req = active
  - x = h and y = v in RUN; x = y = 0 in IDLE
- Delay line:
  - {~active, vs_raw, hs_raw} pass through a PIX_LAT-deep shift register. It is registered on every clock, including in IDLE.
  - blank is the delayed ~active.
  - ctrl0 = {vs_d, hs_d}, logical (active-high) values.
  - hsync = hs_d ? HS_POL : ~HS_POL. vsync is formed the same way from vs_d and VS_POL.
  - PIX_LAT=0 means the outputs are combinational from the counters.
- Reset values:
  - running=0, pix_req=0, x=y=0, frame_start=0, line_start=0
  - blank=1, ctrl0=2'b00
  - hsync=~HS_POL, vsync=~VS_POL
  - every shift-register stage = {1,0,0}
- Reset mid-operation: all outputs reach their reset values asynchronously. Nothing resumes until reset releases and en=1 is sampled.
- After RUN → IDLE, the delay line drains: blank stays 1 and syncs go inactive within PIX_LAT clocks.
- Control codes in blanking reach the encoder via ctrl0 only; lanes 1 and 2 are tied to 2'b00 at top level.

Test Plan:
- Reset, then en=1 held, defaults: first pix_req on clock 1 after en is sampled. blank falls exactly 2 clocks after pix_req rises. pix_req is high for 640 consecutive clocks per active line.
- Horizontal sync: hsync goes low at delayed h=656, for 96 clocks, then high. ctrl0[0]=1 for those same 96 clocks. line_start period is 800 clocks.
- Full frame: frame_start period is 420000 clocks. vsync is low for exactly 1600 clocks, starting at line 490, h=0 (+2-clock latency). blank is high for all of lines 480..524.
- Stop: en dropped at v=100, h=300. The FSM stays in RUN until h=799, v=524, then running=0. No frame_start follows. blank=1 and syncs are inactive within 2 clocks.
- Async reset asserted at h=200, v=50 during active video: blank=1, hsync=vsync=1, pix_req=0 immediately, with no clock edge.
- PIX_LAT=0 and HS_POL=1 build: blank is the exact complement of pix_req in the same cycle. hsync is high during h=656..751.

Source files
------------

// File: rtl/hdmi_video_timing.sv
// rtl/hdmi_video_timing.sv - video timing controller for the three HDMI TMDS encoder lanes
//
// Ports:
//   clk         pixel clock
//   arst_n      asynchronous active-low reset
//   en          run request; stopping only takes effect at the last clock of a frame
//   pix_req     renderer must present the pixel at (x,y) PIX_LAT clocks later
//   x, y        current position (counter domain, undelayed, 0 while idle)
//   frame_start one-clock pulse at h=0, v=0 (undelayed)
//   line_start  one-clock pulse at h=0 of every line (undelayed)
//   blank       encoder blank input, delayed by PIX_LAT
//   ctrl0       {vsync,hsync} active-high for lane 0, delayed by PIX_LAT
//   hsync       delayed hsync at HS_POL level when active
//   vsync       delayed vsync at VS_POL level when active
//   running     high while the timing generator is running
//   Lanes 1 and 2 carry no control code; their c inputs are tied to 2'b00 by the encoder top.
module hdmi_video_timing #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   PIX_LAT  = 2
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        en,
  output logic        pix_req,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_start,
  output logic        line_start,
  output logic        blank,
  output logic [1:0]  ctrl0,
  output logic        hsync,
  output logic        vsync,
  output logic        running
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOT - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOT - 1);

  // Window bounds are 13 bits so an end bound equal to 4096 still compares correctly.
  localparam logic [12:0] H_ACT  = 13'(H_ACTIVE);
  localparam logic [12:0] HS_BEG = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_ACT  = 13'(V_ACTIVE);
  localparam logic [12:0] VS_BEG = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END = 13'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_n;
  logic [11:0] h, h_n, v, v_n;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
      h     <= '0;
      v     <= '0;
    end else begin
      state <= state_n;
      h     <= h_n;
      v     <= v_n;
    end
  end

  always_comb begin
    state_n = state;
    h_n     = h;
    v_n     = v;
    case (state)
      IDLE: begin
        h_n = '0;
        v_n = '0;
        if (en) state_n = RUN;
      end
      RUN: begin
        if (h == H_LAST) begin
          h_n = '0;
          if (v == V_LAST) begin
            v_n = '0;
            // Frames are never truncated: en is only honoured on the final clock.
            if (!en) state_n = IDLE;
          end else begin
            v_n = v + 12'd1;
          end
        end else begin
          h_n = h + 12'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  logic       active, hs_raw, vs_raw;
  logic [2:0] raw, dly_out;

  assign running = (state == RUN);
  assign active  = running && ({1'b0, h} < H_ACT) && ({1'b0, v} < V_ACT);
  assign hs_raw  = running && ({1'b0, h} >= HS_BEG) && ({1'b0, h} < HS_END);
  assign vs_raw  = running && ({1'b0, v} >= VS_BEG) && ({1'b0, v} < VS_END);
  assign raw     = {~active, vs_raw, hs_raw};

  assign pix_req     = active;
  assign x           = running ? h : '0;
  assign y           = running ? v : '0;
  assign line_start  = running && (h == '0);
  assign frame_start = running && (h == '0) && (v == '0);

  // Delay line aligns blank/sync with the renderer's pixel pipeline. It keeps
  // shifting while idle so it drains to the blanked, sync-inactive pattern.
  if (PIX_LAT == 0) begin : g_nodly
    assign dly_out = raw;
  end else begin : g_dly
    logic [2:0] sr [PIX_LAT];
    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        for (int i = 0; i < PIX_LAT; i++) sr[i] <= 3'b100;
      end else begin
        sr[0] <= raw;
        for (int i = 1; i < PIX_LAT; i++) sr[i] <= sr[i-1];
      end
    end
    assign dly_out = sr[PIX_LAT-1];
  end

  assign blank = dly_out[2];
  assign ctrl0 = dly_out[1:0];
  assign hsync = dly_out[0] ? HS_POL : ~HS_POL;
  assign vsync = dly_out[1] ? VS_POL : ~VS_POL;

endmodule
